// File: rtl/buffered_ram_arbiter_pkg.sv
// Shared constants and types for buffered_ram_arbiter and its round-robin sub-arbiter.
// Read latency matches the fixed 2-cycle latency of buffered_ram.
package buffered_ram_arbiter_pkg;

    localparam int RD_LATENCY  = 2;
    localparam int NUM_CLIENTS = 2;

    typedef logic client_id_t;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-input round-robin arbiter: combinational one-hot grant, registered priority pointer.
// The pointer only flips after a contested grant, so an uncontested client never loses its turn.
module rr_arbiter2
    import buffered_ram_arbiter_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] req,
    output logic [1:0] grant
);

    client_id_t ptr_reg;
    client_id_t ptr_next;

    // Grants are suppressed while reset is asserted so no ack leaks out mid-reset.
    always_comb begin
        grant    = 2'b00;
        ptr_next = ptr_reg;
        if (rst_n) begin
            if (&req) begin
                grant[ptr_reg] = 1'b1;
                ptr_next       = ~ptr_reg;
            end else begin
                grant = req;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_reg <= 1'b0;
        end else begin
            ptr_reg <= ptr_next;
        end
    end

endmodule

// File: rtl/buffered_ram_arbiter.sv
// Two-client arbiter/sequencer for buffered_ram: independent round-robin write and read ports,
// 2-cycle read tag pipe for routing returns. Define RAM_ARB_WRFWD_EN to forward colliding writes.
module buffered_ram_arbiter
    import buffered_ram_arbiter_pkg::*;
#(
    parameter int p_addresswidth = 8,
    parameter int p_datawidth    = 16
) (
    input  logic                      inclk,
    input  logic                      inrst_n,
    input  logic                      in_c0_wrreq,
    input  logic [p_addresswidth-1:0] in_c0_wraddress,
    input  logic [p_datawidth-1:0]    in_c0_wrdata,
    output logic                      out_c0_wrack,
    input  logic                      in_c0_rdreq,
    input  logic [p_addresswidth-1:0] in_c0_rdaddress,
    output logic                      out_c0_rdack,
    output logic                      out_c0_rdvalid,
    output logic [p_datawidth-1:0]    out_c0_rddata,
    input  logic                      in_c1_wrreq,
    input  logic [p_addresswidth-1:0] in_c1_wraddress,
    input  logic [p_datawidth-1:0]    in_c1_wrdata,
    output logic                      out_c1_wrack,
    input  logic                      in_c1_rdreq,
    input  logic [p_addresswidth-1:0] in_c1_rdaddress,
    output logic                      out_c1_rdack,
    output logic                      out_c1_rdvalid,
    output logic [p_datawidth-1:0]    out_c1_rddata,
    output logic                      out_ram_wren,
    output logic [p_addresswidth-1:0] out_ram_wraddress,
    output logic [p_datawidth-1:0]    out_ram_wrdata,
    output logic [p_addresswidth-1:0] out_ram_rdaddress,
    input  logic [p_datawidth-1:0]    in_ram_rddata
);

    logic [NUM_CLIENTS-1:0]    wr_req;
    logic [NUM_CLIENTS-1:0]    wr_gnt;
    logic [NUM_CLIENTS-1:0]    rd_req;
    logic [NUM_CLIENTS-1:0]    rd_gnt;
    client_id_t                wr_id;
    client_id_t                rd_id;
    logic                      rd_any;
    logic [p_addresswidth-1:0] rd_sel_addr;
    logic [p_addresswidth-1:0] rdaddr_reg;
    logic [RD_LATENCY-1:0]     tag_valid_reg;
    logic [RD_LATENCY-1:0]     tag_valid_next;
    client_id_t                tag_id_reg  [RD_LATENCY];
    client_id_t                tag_id_next [RD_LATENCY];
    logic                      ret_valid;
    client_id_t                ret_id;
    logic [p_datawidth-1:0]    ret_data;

    assign wr_req = {in_c1_wrreq, in_c0_wrreq};
    assign rd_req = {in_c1_rdreq, in_c0_rdreq};

    rr_arbiter2 u_wr_arb (
        .clk   (inclk),
        .rst_n (inrst_n),
        .req   (wr_req),
        .grant (wr_gnt)
    );

    rr_arbiter2 u_rd_arb (
        .clk   (inclk),
        .rst_n (inrst_n),
        .req   (rd_req),
        .grant (rd_gnt)
    );

    assign out_c0_wrack      = wr_gnt[0];
    assign out_c1_wrack      = wr_gnt[1];
    assign wr_id             = wr_gnt[1];
    assign out_ram_wren      = |wr_gnt;
    assign out_ram_wraddress = wr_id ? in_c1_wraddress : in_c0_wraddress;
    assign out_ram_wrdata    = wr_id ? in_c1_wrdata    : in_c0_wrdata;

    assign out_c0_rdack      = rd_gnt[0];
    assign out_c1_rdack      = rd_gnt[1];
    assign rd_any            = |rd_gnt;
    assign rd_id             = rd_gnt[1];
    assign rd_sel_addr       = rd_id ? in_c1_rdaddress : in_c0_rdaddress;
    // Idle cycles keep the previous address on the RAM read port.
    assign out_ram_rdaddress = rd_any ? rd_sel_addr : rdaddr_reg;

    genvar gi;
    generate
        for (gi = 0; gi < RD_LATENCY; gi++) begin : g_tag
            if (gi == 0) begin : g_head
                assign tag_valid_next[gi] = rd_any;
                assign tag_id_next[gi]    = rd_id;
            end else begin : g_body
                assign tag_valid_next[gi] = tag_valid_reg[gi-1];
                assign tag_id_next[gi]    = tag_id_reg[gi-1];
            end
        end
    endgenerate

    always_ff @(posedge inclk or negedge inrst_n) begin
        if (!inrst_n) begin
            tag_valid_reg <= '0;
            rdaddr_reg    <= '0;
            for (int i = 0; i < RD_LATENCY; i++) begin
                tag_id_reg[i] <= 1'b0;
            end
        end else begin
            tag_valid_reg <= tag_valid_next;
            rdaddr_reg    <= out_ram_rdaddress;
            for (int i = 0; i < RD_LATENCY; i++) begin
                tag_id_reg[i] <= tag_id_next[i];
            end
        end
    end

    assign ret_valid = tag_valid_reg[RD_LATENCY-1];
    assign ret_id    = tag_id_reg[RD_LATENCY-1];

`ifdef RAM_ARB_WRFWD_EN
    logic                   fwd_hit;
    logic [RD_LATENCY-1:0]  fwd_hit_reg;
    logic [p_datawidth-1:0] fwd_data_reg [RD_LATENCY];

    // The RAM returns pre-write contents on a same-cycle collision; capture the new word instead.
    assign fwd_hit = rd_any && out_ram_wren && (out_ram_wraddress == rd_sel_addr);

    always_ff @(posedge inclk or negedge inrst_n) begin
        if (!inrst_n) begin
            fwd_hit_reg <= '0;
            for (int i = 0; i < RD_LATENCY; i++) begin
                fwd_data_reg[i] <= '0;
            end
        end else begin
            fwd_hit_reg     <= {fwd_hit_reg[RD_LATENCY-2:0], fwd_hit};
            fwd_data_reg[0] <= out_ram_wrdata;
            for (int i = 1; i < RD_LATENCY; i++) begin
                fwd_data_reg[i] <= fwd_data_reg[i-1];
            end
        end
    end

    assign ret_data = fwd_hit_reg[RD_LATENCY-1] ? fwd_data_reg[RD_LATENCY-1] : in_ram_rddata;
`else
    assign ret_data = in_ram_rddata;
`endif

    assign out_c0_rdvalid = ret_valid && (ret_id == 1'b0);
    assign out_c1_rdvalid = ret_valid && (ret_id == 1'b1);
    assign out_c0_rddata  = ret_data;
    assign out_c1_rddata  = ret_data;

endmodule

// File: tb/tb_buffered_ram_arbiter.sv
// Self-checking bench for buffered_ram_arbiter with a local 2-cycle RAM and a transaction-level model.
// Honours RAM_ARB_WRFWD_EN when the same define is given to the build.
module tb_buffered_ram_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        c0_wrreq, c1_wrreq, c0_rdreq, c1_rdreq;
    logic [7:0]  c0_wraddr, c1_wraddr, c0_rdaddr, c1_rdaddr;
    logic [15:0] c0_wrdata, c1_wrdata;
    logic        c0_wrack, c1_wrack, c0_rdack, c1_rdack, c0_rdvalid, c1_rdvalid;
    logic [15:0] c0_rddata, c1_rddata;
    logic        ram_wren;
    logic [7:0]  ram_wraddr, ram_rdaddr;
    logic [15:0] ram_wrdata, ram_rddata;

    int tests  = 0;
    int errors = 0;

    always #5 clk = ~clk;

    buffered_ram_arbiter #(.p_addresswidth(8), .p_datawidth(16)) dut (
        .inclk(clk), .inrst_n(rst_n),
        .in_c0_wrreq(c0_wrreq), .in_c0_wraddress(c0_wraddr), .in_c0_wrdata(c0_wrdata),
        .out_c0_wrack(c0_wrack),
        .in_c0_rdreq(c0_rdreq), .in_c0_rdaddress(c0_rdaddr), .out_c0_rdack(c0_rdack),
        .out_c0_rdvalid(c0_rdvalid), .out_c0_rddata(c0_rddata),
        .in_c1_wrreq(c1_wrreq), .in_c1_wraddress(c1_wraddr), .in_c1_wrdata(c1_wrdata),
        .out_c1_wrack(c1_wrack),
        .in_c1_rdreq(c1_rdreq), .in_c1_rdaddress(c1_rdaddr), .out_c1_rdack(c1_rdack),
        .out_c1_rdvalid(c1_rdvalid), .out_c1_rddata(c1_rddata),
        .out_ram_wren(ram_wren), .out_ram_wraddress(ram_wraddr), .out_ram_wrdata(ram_wrdata),
        .out_ram_rdaddress(ram_rdaddr), .in_ram_rddata(ram_rddata)
    );

    // Stand-in for buffered_ram: write at the edge, read data two edges after the address.
    logic [15:0] ram_mem [256];
    logic [15:0] ram_q1, ram_q2;
    logic        ram_ready = 1'b0;
    assign ram_rddata = ram_q2;

    always @(posedge clk) begin
        if (!ram_ready) begin
            for (int i = 0; i < 256; i++) ram_mem[i] <= 16'h0000;
            ram_ready <= 1'b1;
        end else if (ram_wren) begin
            ram_mem[ram_wraddr] <= ram_wrdata;
        end
        ram_q1 <= ram_mem[ram_rdaddr];
        ram_q2 <= ram_q1;
    end

    // Reference model: memory contents, whose turn it is per port, and a list of promised returns.
    typedef struct { int due; bit id; logic [15:0] data; } ret_t;
    ret_t        exp_q[$];
    logic [15:0] m_mem [256];
    bit          m_wturn, m_rturn;
    logic [7:0]  m_last_raddr;
    int          cyc = 0;

    function automatic logic [1:0] pick(input logic [1:0] req, input bit turn);
        if (!rst_n) return 2'b00;
        if (req == 2'b11) return turn ? 2'b10 : 2'b01;
        return req;
    endfunction

    function automatic bit exp_rv(input bit id);
        return exp_q.size() != 0 && exp_q[0].due == cyc && exp_q[0].id == id;
    endfunction

    function automatic logic [15:0] exp_rd();
        return (exp_q.size() != 0) ? exp_q[0].data : 16'h0000;
    endfunction

    task automatic model_reset();
        exp_q.delete();
        m_wturn = 1'b0;
        m_rturn = 1'b0;
        m_last_raddr = 8'h00;
    endtask

    // Close the current cycle in the model, then advance to just after the next rising edge.
    task automatic tick();
        logic [1:0]  wg, rg;
        logic [7:0]  wa, ra;
        logic [15:0] wd, d;
        wg = pick({c1_wrreq, c0_wrreq}, m_wturn);
        rg = pick({c1_rdreq, c0_rdreq}, m_rturn);
        wa = wg[1] ? c1_wraddr : c0_wraddr;
        wd = wg[1] ? c1_wrdata : c0_wrdata;
        ra = rg[1] ? c1_rdaddr : c0_rdaddr;
        if (rst_n) begin
            if (exp_q.size() != 0 && exp_q[0].due == cyc) void'(exp_q.pop_front());
            if (rg != 2'b00) begin
                d = m_mem[ra];
`ifdef RAM_ARB_WRFWD_EN
                if (wg != 2'b00 && wa == ra) d = wd;
`endif
                exp_q.push_back('{cyc + 2, rg[1], d});
                m_last_raddr = ra;
            end
            if (wg != 2'b00) m_mem[wa] = wd;
            if (c0_wrreq && c1_wrreq) m_wturn = ~m_wturn;
            if (c0_rdreq && c1_rdreq) m_rturn = ~m_rturn;
        end
        cyc++;
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        c0_wrreq = 1'b0; c1_wrreq = 1'b0; c0_rdreq = 1'b0; c1_rdreq = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        model_reset();
        c0_wrreq = 1'b1; c0_wraddr = 8'h01; c0_wrdata = 16'h1111;
        c1_wrreq = 1'b0; c0_rdreq = 1'b0;
        c1_rdreq = 1'b1; c1_rdaddr = 8'h02; c1_wraddr = 8'h00; c1_wrdata = 16'h0; c0_rdaddr = 8'h00;
        @(negedge clk);
        tests++; if (c0_wrack !== 1'b0 || ram_wren !== 1'b0) begin errors++;
            $display("FAIL reset_wr: wrack=%b wren=%b want 0/0", c0_wrack, ram_wren); end
        tests++; if (c1_rdack !== 1'b0 || ram_rdaddr !== 8'h00) begin errors++;
            $display("FAIL reset_rd: rdack=%b rdaddr=%h want 0/00", c1_rdack, ram_rdaddr); end
        tests++; if (c0_rdvalid !== 1'b0 || c1_rdvalid !== 1'b0) begin errors++;
            $display("FAIL reset_rdvalid: %b%b want 00", c1_rdvalid, c0_rdvalid); end
        tick(); tick();
        idle();
        rst_n = 1'b1;
        $display("[TB] reset released at cycle %0d", cyc);
    endtask

    task automatic test_write_then_read();
        c0_wrreq = 1'b1; c0_wraddr = 8'h05; c0_wrdata = 16'h1234;
        @(negedge clk);
        tests++; if (c0_wrack !== 1'b1 || ram_wren !== 1'b1 || ram_wraddr !== 8'h05 || ram_wrdata !== 16'h1234) begin
            errors++; $display("FAIL wr_grant: ack=%b wren=%b addr=%h data=%h want 1/1/05/1234",
                               c0_wrack, ram_wren, ram_wraddr, ram_wrdata); end
        tick();
        c0_wrreq = 1'b0; c1_rdreq = 1'b1; c1_rdaddr = 8'h05;
        @(negedge clk);
        tests++; if (c1_rdack !== 1'b1 || ram_rdaddr !== 8'h05 || ram_wren !== 1'b0) begin errors++;
            $display("FAIL rd_grant: ack=%b addr=%h wren=%b want 1/05/0", c1_rdack, ram_rdaddr, ram_wren); end
        tick();
        c1_rdreq = 1'b0;
        @(negedge clk);
        tests++; if (c0_rdvalid !== 1'b0 || c1_rdvalid !== 1'b0) begin errors++;
            $display("FAIL rd_early: valid=%b%b want 00", c1_rdvalid, c0_rdvalid); end
        tick();
        @(negedge clk);
        tests++; if (c1_rdvalid !== 1'b1 || c0_rdvalid !== 1'b0 || c1_rddata !== 16'h1234) begin errors++;
            $display("FAIL wr_rd_return: v1=%b v0=%b data=%h want 1/0/1234", c1_rdvalid, c0_rdvalid, c1_rddata); end
        tick();
        $display("[TB] write-then-read done, c1 got %h", 16'h1234);
    endtask

    task automatic test_contended_reads();
        logic [15:0] want;
        c0_wrreq = 1'b1; c0_wraddr = 8'h10; c0_wrdata = 16'hAAAA; tick();
        c0_wrreq = 1'b0; c1_wrreq = 1'b1; c1_wraddr = 8'h20; c1_wrdata = 16'h5555; tick();
        c1_wrreq = 1'b0;
        c0_rdaddr = 8'h10; c1_rdaddr = 8'h20;
        for (int i = 0; i < 8; i++) begin
            c0_rdreq = (i < 6); c1_rdreq = (i < 6);
            @(negedge clk);
            if (i < 6) begin
                tests++; if (c0_rdack !== (i % 2 == 0) || c1_rdack !== (i % 2 == 1)) begin errors++;
                    $display("FAIL rr_rdack[%0d]: ack=%b%b want %b%b", i, c1_rdack, c0_rdack, (i % 2 == 1), (i % 2 == 0)); end
            end
            want = (i % 2 == 0) ? 16'hAAAA : 16'h5555;
            if (i >= 2) begin
                tests++; if (c0_rdvalid !== (i % 2 == 0) || c1_rdvalid !== (i % 2 == 1) || c0_rddata !== want) begin
                    errors++; $display("FAIL rr_return[%0d]: valid=%b%b data=%h want %b%b/%h",
                                       i, c1_rdvalid, c0_rdvalid, c0_rddata, (i % 2 == 1), (i % 2 == 0), want); end
            end else begin
                tests++; if (c0_rdvalid !== 1'b0 || c1_rdvalid !== 1'b0) begin errors++;
                    $display("FAIL rr_early[%0d]: valid=%b%b want 00", i, c1_rdvalid, c0_rdvalid); end
            end
            tick();
        end
        idle();
        $display("[TB] contended reads done at cycle %0d", cyc);
    endtask

    task automatic test_collision();
        logic [15:0] want;
`ifdef RAM_ARB_WRFWD_EN
        want = 16'hBEEF;
`else
        want = 16'h0001;
`endif
        c1_wrreq = 1'b1; c1_wraddr = 8'h07; c1_wrdata = 16'h0001; tick();
        c1_wrreq = 1'b0;
        c0_wrreq = 1'b1; c0_wraddr = 8'h07; c0_wrdata = 16'hBEEF;
        c1_rdreq = 1'b1; c1_rdaddr = 8'h07;
        @(negedge clk);
        tests++; if (c0_wrack !== 1'b1 || c1_rdack !== 1'b1) begin errors++;
            $display("FAIL coll_grant: wrack=%b rdack=%b want 1/1", c0_wrack, c1_rdack); end
        tick();
        c0_wrreq = 1'b0; c1_rdreq = 1'b0; c0_rdreq = 1'b1; c0_rdaddr = 8'h07;
        tick();
        c0_rdreq = 1'b0;
        @(negedge clk);
        tests++; if (c1_rdvalid !== 1'b1 || c1_rddata !== want) begin errors++;
            $display("FAIL coll_data: valid=%b data=%h want 1/%h", c1_rdvalid, c1_rddata, want); end
        tick();
        @(negedge clk);
        tests++; if (c0_rdvalid !== 1'b1 || c0_rddata !== 16'hBEEF) begin errors++;
            $display("FAIL coll_after: valid=%b data=%h want 1/beef", c0_rdvalid, c0_rddata); end
        tick();
        $display("[TB] collision read returned expected %h", want);
    endtask

    task automatic test_contended_writes();
        rst_n = 1'b0; model_reset(); tick(); rst_n = 1'b1;
        c0_wrreq = 1'b1; c0_wraddr = 8'h30; c0_wrdata = 16'hC0C0;
        c1_wrreq = 1'b1; c1_wraddr = 8'h31; c1_wrdata = 16'hC1C1;
        @(negedge clk);
        tests++; if (c0_wrack !== 1'b1 || c1_wrack !== 1'b0 || ram_wraddr !== 8'h30) begin errors++;
            $display("FAIL cw_first: ack=%b%b addr=%h want 01/30", c1_wrack, c0_wrack, ram_wraddr); end
        tick();
        c0_wrreq = 1'b0;
        @(negedge clk);
        tests++; if (c1_wrack !== 1'b1 || c0_wrack !== 1'b0 || ram_wrdata !== 16'hC1C1) begin errors++;
            $display("FAIL cw_second: ack=%b%b data=%h want 10/c1c1", c1_wrack, c0_wrack, ram_wrdata); end
        tick();
        c1_wrreq = 1'b0;
        c0_rdreq = 1'b1; c0_rdaddr = 8'h30; tick();
        c0_rdreq = 1'b0; c1_rdreq = 1'b1; c1_rdaddr = 8'h31; tick();
        c1_rdreq = 1'b0;
        @(negedge clk);
        tests++; if (c0_rdvalid !== 1'b1 || c0_rddata !== 16'hC0C0) begin errors++;
            $display("FAIL cw_read0: valid=%b data=%h want 1/c0c0", c0_rdvalid, c0_rddata); end
        tick();
        @(negedge clk);
        tests++; if (c1_rdvalid !== 1'b1 || c1_rddata !== 16'hC1C1) begin errors++;
            $display("FAIL cw_read1: valid=%b data=%h want 1/c1c1", c1_rdvalid, c1_rddata); end
        tick();
        $display("[TB] contended writes done at cycle %0d", cyc);
    endtask

    task automatic test_reset_midflight();
        c0_rdreq = 1'b1; c0_rdaddr = 8'h30;
        @(negedge clk);
        tests++; if (c0_rdack !== 1'b1) begin errors++;
            $display("FAIL mf_ack: rdack=%b want 1", c0_rdack); end
        tick();
        c0_rdreq = 1'b0; c1_rdreq = 1'b1; c1_rdaddr = 8'h44;
        c0_wrreq = 1'b1; c0_wraddr = 8'h50; c0_wrdata = 16'h5A5A;
        #2 rst_n = 1'b0;
        model_reset();
        @(negedge clk);
        tests++; if (c0_wrack !== 1'b0 || ram_wren !== 1'b0 || c1_rdack !== 1'b0) begin errors++;
            $display("FAIL mf_acks: wrack=%b wren=%b rdack=%b want 0/0/0", c0_wrack, ram_wren, c1_rdack); end
        tests++; if (ram_rdaddr !== 8'h00 || c0_rdvalid !== 1'b0 || c1_rdvalid !== 1'b0) begin errors++;
            $display("FAIL mf_state: rdaddr=%h valid=%b%b want 00/00", ram_rdaddr, c1_rdvalid, c0_rdvalid); end
        tick();
        c1_rdreq = 1'b0;
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (i == 0) begin
                tests++; if (c0_wrack !== 1'b1) begin errors++;
                    $display("FAIL mf_first_grant: wrack=%b want 1", c0_wrack); end
            end
            tests++; if (c0_rdvalid !== 1'b0 || c1_rdvalid !== 1'b0) begin errors++;
                $display("FAIL mf_dropped[%0d]: valid=%b%b want 00", i, c1_rdvalid, c0_rdvalid); end
            tick();
            c0_wrreq = 1'b0;
        end
        $display("[TB] mid-flight reset dropped in-flight read");
    endtask

    task automatic test_streaming();
        for (int i = 0; i < 10; i++) begin
            c0_rdreq = (i < 8); c0_rdaddr = 8'(8'h40 + i);
            c1_wrreq = (i < 8); c1_wraddr = 8'(8'h41 + i); c1_wrdata = 16'(16'h0700 + i);
            @(negedge clk);
            tests++; if (c0_rdack !== (i < 8)) begin errors++;
                $display("FAIL st_ack[%0d]: rdack=%b want %b", i, c0_rdack, (i < 8)); end
            if (i >= 2) begin
                tests++; if (c0_rdvalid !== 1'b1 || c1_rdvalid !== 1'b0 || c0_rddata !== exp_rd()) begin errors++;
                    $display("FAIL st_ret[%0d]: valid=%b%b data=%h want 01/%h", i, c1_rdvalid, c0_rdvalid, c0_rddata, exp_rd()); end
            end
            tick();
        end
        idle();
        $display("[TB] streaming reads done at cycle %0d", cyc);
    endtask

    task automatic test_random();
        logic [1:0] wg, rg;
        int bad;
        bad = errors;
        for (int n = 0; n < 400; n++) begin
            if (!c0_wrreq && $urandom_range(1, 0) == 1) begin
                c0_wrreq = 1'b1; c0_wraddr = 8'($urandom_range(15, 0)); c0_wrdata = 16'($urandom); end
            if (!c1_wrreq && $urandom_range(1, 0) == 1) begin
                c1_wrreq = 1'b1; c1_wraddr = 8'($urandom_range(15, 0)); c1_wrdata = 16'($urandom); end
            if (!c0_rdreq && $urandom_range(1, 0) == 1) begin
                c0_rdreq = 1'b1; c0_rdaddr = 8'($urandom_range(15, 0)); end
            if (!c1_rdreq && $urandom_range(1, 0) == 1) begin
                c1_rdreq = 1'b1; c1_rdaddr = 8'($urandom_range(15, 0)); end
            @(negedge clk);
            wg = pick({c1_wrreq, c0_wrreq}, m_wturn);
            rg = pick({c1_rdreq, c0_rdreq}, m_rturn);
            tests++; if ({c1_wrack, c0_wrack} !== wg || ram_wren !== (wg != 2'b00)) begin errors++;
                $display("FAIL rnd_wr[%0d]: ack=%b%b wren=%b want %b", n, c1_wrack, c0_wrack, ram_wren, wg); end
            if (wg != 2'b00) begin
                tests++; if (ram_wraddr !== (wg[1] ? c1_wraddr : c0_wraddr) || ram_wrdata !== (wg[1] ? c1_wrdata : c0_wrdata)) begin
                    errors++; $display("FAIL rnd_wrmux[%0d]: addr=%h data=%h", n, ram_wraddr, ram_wrdata); end
            end
            tests++; if ({c1_rdack, c0_rdack} !== rg) begin errors++;
                $display("FAIL rnd_rdack[%0d]: ack=%b%b want %b", n, c1_rdack, c0_rdack, rg); end
            tests++; if (ram_rdaddr !== ((rg != 2'b00) ? (rg[1] ? c1_rdaddr : c0_rdaddr) : m_last_raddr)) begin errors++;
                $display("FAIL rnd_rdaddr[%0d]: got %h", n, ram_rdaddr); end
            tests++; if (c0_rdvalid !== exp_rv(1'b0) || c1_rdvalid !== exp_rv(1'b1)) begin errors++;
                $display("FAIL rnd_valid[%0d]: valid=%b%b want %b%b", n, c1_rdvalid, c0_rdvalid, exp_rv(1'b1), exp_rv(1'b0)); end
            if (exp_rv(1'b0) || exp_rv(1'b1)) begin
                tests++; if (c0_rddata !== exp_rd() || c1_rddata !== exp_rd()) begin errors++;
                    $display("FAIL rnd_data[%0d]: data=%h/%h want %h", n, c0_rddata, c1_rddata, exp_rd()); end
            end
            tick();
            if (wg[0]) c0_wrreq = 1'b0;
            if (wg[1]) c1_wrreq = 1'b0;
            if (rg[0]) c0_rdreq = 1'b0;
            if (rg[1]) c1_rdreq = 1'b0;
        end
        idle();
        $display("[TB] random traffic: 400 cycles, %0d new failures", errors - bad);
    endtask

    initial begin
        for (int i = 0; i < 256; i++) m_mem[i] = 16'h0000;
        test_reset();
        test_write_then_read();
        test_contended_reads();
        test_collision();
        test_contended_writes();
        test_reset_midflight();
        test_streaming();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, errors);
        $finish;
    end

endmodule

// File: doc/buffered_ram_arbiter.md
# buffered_ram_arbiter

Two-client arbiter and sequencer for a `buffered_ram` instance: shares its single write port and single read port between client 0 and client 1 with independent round-robin arbitration per port. Tracks the fixed 2-cycle read latency and routes each returned word to the client that issued it. Sits between the USB command/packet engines and the shared buffer RAM. Optionally forwards same-cycle write data to colliding reads.

## Interface
- `p_addresswidth`, 8: RAM address bits.
- `p_datawidth`, 16: RAM data bits.

- `inclk` in 1: single clock, also drives the RAM.
- `inrst_n` in 1: reset, asynchronous and active-low.
- `in_cN_wrreq` in 1, N=0,1: write request; held until acked.
- `in_cN_wraddress` in p_addresswidth: write address.
- `in_cN_wrdata` in p_datawidth: write data.
- `out_cN_wrack` out 1: combinational grant; write performed at the end of this cycle.
- `in_cN_rdreq` in 1: read request; held until acked.
- `in_cN_rdaddress` in p_addresswidth: read address.
- `out_cN_rdack` out 1: combinational grant; address sampled this cycle.
- `out_cN_rdvalid` out 1: returned data valid for client N, one cycle.
- `out_cN_rddata` out p_datawidth: returned data; meaningful only with `out_cN_rdvalid`.
- `out_ram_wren` out 1, `out_ram_wraddress` out p_addresswidth, `out_ram_wrdata` out p_datawidth: to RAM write port.
- `out_ram_rdaddress` out p_addresswidth: to RAM read port.
- `in_ram_rddata` in p_datawidth: RAM `out_rddata`.

## Operation
- Write and read ports arbitrate independently. A write and a read can both be granted in the same cycle, to the same client or to different clients.
- Per port: single requester is granted immediately. If both request, the priority pointer decides.
  - The pointer resets to client 0.
  - After a contested grant, the pointer moves to the other client.
  - An uncontested grant leaves the pointer unchanged.
- At most one ack per port per cycle. No request is starved: there is at most 1 cycle of wait under continuous contention.
- Write grant: `out_ram_wren`=1, and the address and data of the granted client are muxed onto the RAM write port combinationally. With no grant, `out_ram_wren`=0.
- Read grant: the granted address is driven to `out_ram_rdaddress`. The client ID and a valid bit enter a 2-stage tag shift register.
  - With no grant, the address holds its last value and a 0 valid bit is shifted in.
- Return path: at stage-2 valid, assert `out_cN_rdvalid` for the tagged N. `out_c0_rddata`/`out_c1_rddata` both carry the return-mux output.
- Collision: a read and a write to the same address granted in the same cycle return OLD data (RAM behaviour), unless forwarding is compiled in.
- Reads in consecutive cycles are fully pipelined: throughput is 1 read per cycle.

## Timing
- Write granted in cycle t: the RAM holds the data after edge t.
- Read granted in cycle t: data and `out_cN_rdvalid` appear in cycle t+2.
- A read granted at t+1 after a write at t to the same address returns the NEW data.
- Reset (asynchronous assert, mid-operation included):
  - Tag pipe is cleared and in-flight reads are dropped, with no rdvalid after release.
  - Pointers go to client 0.
  - `out_ram_wren`=0, all acks=0, all rdvalid=0, `out_ram_rdaddress`=0.
  - The first grant is possible in the first cycle after deassertion.

## Configuration
- `RAM_ARB_WRFWD_EN` defined:
  - A same-cycle read/write address match at grant time captures the write data and a hit flag into a 2-stage bypass pipe.
  - At t+2, the returned data is the captured write data instead of `in_ram_rddata`.
- `RAM_ARB_WRFWD_EN` undefined: the bypass pipe is absent, and collision reads return the old RAM contents.

## Structure
- Package `buffered_ram_arbiter_pkg` holds:
  - the read latency constant `RD_LATENCY`=2;
  - the client count constant `NUM_CLIENTS`=2;
  - the client ID type.
- Sub-module `rr_arbiter2`: 2-input round-robin arbiter with registered pointer, request vector in, one-hot grant out. It is instantiated twice, once for write and once for read.
- The RAM itself is instantiated at the parent level, not inside this block.

## Test plan
- Client 0 writes 0x1234 to address 0x05 at t. Client 1 reads 0x05 at t+1 → `out_c1_rdvalid` at t+3 with 0x1234. No c0 rdvalid.
- Both clients hold rdreq continuously to 0x10/0x20 for 6 cycles → acks alternate c0,c1,c0,… and rdvalid alternates 2 cycles later with the correct data.
- Same-cycle write 0xBEEF and read at 0x07, where the old value is 0x0001 → returns 0x0001 without `RAM_ARB_WRFWD_EN`, 0xBEEF with it.
- Both clients request a write in the same cycle from reset → c0 is acked first, c1 the next cycle. The RAM holds both values afterwards.
- Read granted, then `inrst_n` pulsed low at t+1 → no rdvalid at t+2 or later; acks and wren are 0 during reset.
- A single client reading every cycle with no contention → one ack per cycle, with rdvalid continuous from t+2.
